axil_master_bridge: RTL
=======================

# axil_master_bridge

AXI4-Lite master that converts the CPU core's simple single-outstanding request/response memory port into AXI4-Lite read and write transactions. It sits directly upstream of the BRAM AXI-Lite memory and any other AXI-Lite slave on the interconnect, and is the only path by which the core issues loads and stores. It enforces one transaction in flight. It adds a per-transaction timeout so that a hung slave returns an error to the core instead of deadlocking it.

## Interface
- ADDR_WIDTH, 32, address width of the request port and the AXI address channels
- DATA_WIDTH, 32, data width (only 32 supported)
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- TIMEOUT_CYCLES, 1023, maximum cycles a transaction may stay outstanding; 0 disables the timeout
- aclk  in  1  clock; all logic is on the rising edge
- aresetn  in  1  synchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address, passed through unmodified
- req_wdata  in  DATA_WIDTH  store data
- req_wstrb  in  STRB_WIDTH  store byte enables
- resp_valid  out  1  single-cycle response pulse
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- resp_error  out  1  slave returned non-OKAY, or the transaction timed out
- m_axil_awaddr/awprot/awvalid (out), m_axil_awready (in): AW channel; awprot constant 3'b000
- m_axil_wdata/wstrb/wvalid (out), m_axil_wready (in): W channel
- m_axil_bresp[1:0]/bvalid (in), m_axil_bready (out): B channel. Tie bresp to 2'b00 for slaves that do not drive it.
- m_axil_araddr/arprot/arvalid (out), m_axil_arready (in): AR channel; arprot constant 3'b000
- m_axil_rdata/rresp[1:0]/rvalid (in), m_axil_rready (out): R channel

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: req_ready=1. On req_valid, the bridge registers addr, wdata, wstrb and write. It then goes to WR_ADDR_DATA if write, otherwise RD_ADDR.
- WR_ADDR_DATA:
  - awvalid and wvalid are raised together.
  - Each channel drops independently on the cycle after its own handshake; an aw_done/w_done flag records completion.
  - Once both handshakes are complete, go to WR_RESP. This includes the case where both complete in the same cycle.
- WR_RESP: bready=1. On bvalid, go to IDLE with resp_error = (bresp != 2'b00).
- RD_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and set resp_error = (rresp != 2'b00), then go to IDLE.
  - On error, resp_rdata is 0 rather than the returned data.
- bready and rready are 0 outside their own states. AW/W/AR payloads are held stable while their valid is high.
- Timeout:
  - A counter clears on request acceptance and increments every cycle outside IDLE.
  - On reaching TIMEOUT_CYCLES, all valids and readies drop, the bridge returns to IDLE and emits resp_valid with resp_error=1 and resp_rdata=0.
  - A late B/R after a timeout is not consumed. A late B/R arriving during a later transaction is accepted as that transaction's response. This is a debug-only recovery path, not AXI-compliant.
- Requests presented while req_ready=0 are ignored; the core holds req_valid until accepted.

## Timing
- Reset (aresetn=0 at an edge): state IDLE, and on the following edge all of the following are 0:
  - req_ready=1
  - resp_valid, resp_error and resp_rdata
  - awvalid, wvalid, arvalid, bready and rready
  - timeout counter
- Reset mid-transaction aborts silently: no resp_valid is produced.
- All outputs are registered, with no combinational path from any input to any output.
- Request accepted at edge N:
  - awvalid/wvalid (or arvalid) are high from N+1.
  - The B or R handshake happens in the state entered after the address handshake.
  - resp_valid pulses for exactly one cycle, on the edge after the B/R handshake.
- Against an always-ready, zero-wait slave (the BRAM memory), a request accepted at edge 0 gives:
  - address handshake at edge 1
  - B/R handshake at edge 2
  - resp_valid high in cycle 3
  - req_ready high again in cycle 3
- A new request may therefore be accepted every 3 cycles. A request can be accepted in the same cycle resp_valid is high.
- Timeout fires TIMEOUT_CYCLES cycles after acceptance. resp_valid follows one cycle later.

## Test plan
- Write of addr 0x100, data 0xDEADBEEF, strb 4'hF to a zero-wait slave -> AW/W handshake at edge 1, B at edge 2, resp_valid at cycle 3 with resp_error=0 and resp_rdata=0.
- Read of 0x100 after that write -> araddr=0x100, rdata 0xDEADBEEF captured, resp_valid at cycle 3 with resp_rdata=0xDEADBEEF and resp_error=0.
- Slave holds wready low 5 cycles while awready=1 -> awvalid drops after 1 cycle, wvalid stays high with stable wdata until the handshake, bready rises only after the W handshake, single resp_valid.
- Slave returns rresp=2'b10 with rdata=0x12345678 -> resp_error=1, resp_rdata=0.
- TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops and resp_valid pulses with resp_error=1 at cycle 17, then req_ready=1.
- aresetn=0 asserted in RD_DATA for 1 cycle -> all outputs at reset values on the next edge, no resp_valid, and the next request completes normally.

Source files
------------

// File: rtl/axil_master_bridge_if.sv
// AXI4-Lite bus bundle between the request bridge (master) and the
// interconnect / memory side (slave). Widths follow the bridge parameters.
interface axil_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // Write address channel
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    // Write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    // Write response channel
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Read address channel
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    // Read data channel
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axil_master_bridge.sv
// Converts the core's single-outstanding request/response port into
// AXI4-Lite read/write transactions. One transaction in flight; a per-
// transaction timeout turns a hung slave into an error response.
// Every output comes straight from a register.
module axil_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,

    axil_master_bridge_if.master  m_axil
);

    // Timer is just wide enough to hold TIMEOUT_CYCLES; a value of 0 disables it.
    localparam int              TIMER_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
    localparam bit              TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] wstrb_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  arvalid_reg;
    logic                  bready_reg;
    logic                  rready_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic [TIMER_W-1:0]    timer_reg;
    logic                  req_ready_reg;
    logic                  resp_valid_reg;
    logic                  resp_error_reg;
    logic [DATA_WIDTH-1:0] resp_rdata_reg;

    // Handshakes completing at the coming edge.
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;
    logic timer_expired;

    assign aw_hs = awvalid_reg & m_axil.awready;
    assign w_hs  = wvalid_reg  & m_axil.wready;
    assign ar_hs = arvalid_reg & m_axil.arready;
    assign b_hs  = bready_reg  & m_axil.bvalid;
    assign r_hs  = rready_reg  & m_axil.rvalid;

    // The timer holds the count of elapsed busy edges minus one, so the abort
    // edge is exactly TIMEOUT_CYCLES edges after acceptance.
    assign timer_expired = TIMEOUT_EN && (state_reg != IDLE) &&
                           ((timer_reg + TIMER_W'(1)) == TIMER_LIMIT);

    // Request-side outputs.
    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_error = resp_error_reg;
    assign resp_rdata = resp_rdata_reg;

    // AXI-side outputs; address is shared by AW and AR since only one is ever live.
    assign m_axil.awaddr  = addr_reg;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_reg;
    assign m_axil.wdata   = wdata_reg;
    assign m_axil.wstrb   = wstrb_reg;
    assign m_axil.wvalid  = wvalid_reg;
    assign m_axil.bready  = bready_reg;
    assign m_axil.araddr  = addr_reg;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_reg;
    assign m_axil.rready  = rready_reg;

    // Transaction FSM: accepts a request, walks the AXI channels, and produces
    // a one-cycle response pulse on completion or timeout.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            bready_reg     <= 1'b0;
            rready_reg     <= 1'b0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            timer_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // req_ready is high throughout IDLE, so req_valid alone accepts.
                    if (req_valid) begin
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        wstrb_reg     <= req_wstrb;
                        req_ready_reg <= 1'b0;
                        timer_reg     <= '0;
                        aw_done_reg   <= 1'b0;
                        w_done_reg    <= 1'b0;
                        if (req_write) begin
                            state_reg   <= WR_ADDR_DATA;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD_ADDR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    timer_reg <= timer_reg + TIMER_W'(1);
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    // Either channel may finish first, or both on the same edge.
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        state_reg  <= WR_RESP;
                        bready_reg <= 1'b1;
                    end
                end

                WR_RESP: begin
                    timer_reg <= timer_reg + TIMER_W'(1);
                    if (b_hs) begin
                        state_reg      <= IDLE;
                        bready_reg     <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        resp_error_reg <= (m_axil.bresp != 2'b00);
                        resp_rdata_reg <= '0;
                    end
                end

                RD_ADDR: begin
                    timer_reg <= timer_reg + TIMER_W'(1);
                    if (ar_hs) begin
                        state_reg   <= RD_DATA;
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                    end
                end

                RD_DATA: begin
                    timer_reg <= timer_reg + TIMER_W'(1);
                    if (r_hs) begin
                        state_reg      <= IDLE;
                        rready_reg     <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        resp_error_reg <= (m_axil.rresp != 2'b00);
                        resp_rdata_reg <= (m_axil.rresp == 2'b00) ? m_axil.rdata : '0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // A genuine B/R response on the expiry edge wins over the timeout.
            if (timer_expired && !(b_hs || r_hs)) begin
                state_reg      <= IDLE;
                awvalid_reg    <= 1'b0;
                wvalid_reg     <= 1'b0;
                arvalid_reg    <= 1'b0;
                bready_reg     <= 1'b0;
                rready_reg     <= 1'b0;
                timer_reg      <= '0;
                req_ready_reg  <= 1'b1;
                resp_valid_reg <= 1'b1;
                resp_error_reg <= 1'b1;
                resp_rdata_reg <= '0;
            end
        end
    end

endmodule
